// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the serial program loader.
// State encoding, protocol words and the inter-word timeout helper.
package uart_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        GET_DATA,
        WRITE,
        SEND_RESP,
        RST_PULSE
    } state_e;

    localparam logic [31:0] CMD_PROG = 32'h50524F47;
    localparam logic [31:0] CMD_RST  = 32'h52535430;
    localparam logic [31:0] NAK      = 32'hFFFFFFFF;
    localparam logic [31:0] TMO      = 32'hFFFFFFFE;

    // Clock cycles allowed between words; clamped to 1 so an
    // un-overridden CLK_RATE still elaborates.
    function automatic int TIMEOUT_CLKS(input int clk_rate,
                                        input int iw_timeout_ms);
        int t;
        t = clk_rate * iw_timeout_ms * 1000;
        return (t > 0) ? t : 1;
    endfunction

endpackage

// File: rtl/uart_prog_ctrl_timeout.sv
// Inter-word timeout counter: cleared on kick, counts while run_i,
// saturates at LIMIT. Ports: kick_i, run_i in; expired_o out.
module prog_timeout_ctr #(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic kick_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (kick_i)
            cnt_d = '0;
        else if (run_i && cnt_q != LIM)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // A word arriving in the expiry cycle wins over the timeout.
    assign expired_o = run_i && !kick_i && (cnt_q == LIM);

endmodule

// File: rtl/uart_prog_ctrl.sv
// Serial bootloader command sequencer: parses PROG/RST word commands,
// writes payload to memory via req/ack, replies with one status word.
// Ports: rx_ready/rx_word in; mem_* write port; tx_* response;
// mcu_hold/mcu_rst MCU control; error sticky overrun flag.
module uart_prog_ctrl
    import uart_prog_pkg::*;
#(
    parameter int CLK_RATE   = -1,
    parameter int IW_TIMEOUT = 200,
    parameter int MAX_WORDS  = 16384,
    parameter int RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ready,
    input  logic [31:0] rx_word,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        tx_start,
    output logic [31:0] tx_word,
    input  logic        tx_busy,
    output logic        mcu_hold,
    output logic        mcu_rst,
    output logic        error
);

    localparam int TMO_CLKS = TIMEOUT_CLKS(CLK_RATE, IW_TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] txw_q, txw_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic        we_q, we_d;
    logic        txs_q, txs_d;
    logic        hold_q, hold_d;
    logic        mrst_q, mrst_d;
    logic        err_q, err_d;

    logic        tmo_run, tmo_kick, tmo_exp;

    // Timer runs only while waiting for a word; it pauses in WRITE
    // and is held clear everywhere else.
    assign tmo_run  = (state_q == GET_ADDR) || (state_q == GET_LEN) ||
                      (state_q == GET_DATA);
    assign tmo_kick = rx_ready || !(tmo_run || state_q == WRITE);

    prog_timeout_ctr #(.LIMIT(TMO_CLKS)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .kick_i    (tmo_kick),
        .run_i     (tmo_run),
        .expired_o (tmo_exp)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        din_d   = din_q;
        txw_d   = txw_q;
        rcnt_d  = rcnt_q;
        we_d    = we_q;
        txs_d   = 1'b0;
        hold_d  = hold_q;
        mrst_d  = mrst_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    if (rx_word == CMD_PROG) begin
                        state_d = GET_ADDR;
                        hold_d  = 1'b1;
                        sum_d   = '0;
                        idx_d   = '0;
                        err_d   = 1'b0;
                    end else if (rx_word == CMD_RST) begin
                        state_d = RST_PULSE;
                        mrst_d  = 1'b1;
                        rcnt_d  = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = SEND_RESP;
                        txw_d   = NAK;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_ready) begin
                    base_d  = {rx_word[31:2], 2'b00};
                    state_d = GET_LEN;
                end else if (tmo_exp) begin
                    state_d = SEND_RESP;
                    txw_d   = TMO;
                end
            end
            GET_LEN: begin
                if (rx_ready) begin
                    len_d = rx_word;
                    idx_d = '0;
                    if (rx_word == '0) begin
                        state_d = SEND_RESP;
                        txw_d   = sum_q;
                    end else if (rx_word > 32'(MAX_WORDS)) begin
                        state_d = SEND_RESP;
                        txw_d   = NAK;
                    end else begin
                        state_d = GET_DATA;
                    end
                end else if (tmo_exp) begin
                    state_d = SEND_RESP;
                    txw_d   = TMO;
                end
            end
            GET_DATA: begin
                if (rx_ready) begin
                    addr_d  = base_q + (idx_q << 2);
                    din_d   = rx_word;
                    sum_d   = sum_q + rx_word;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end else if (tmo_exp) begin
                    state_d = SEND_RESP;
                    txw_d   = TMO;
                end
            end
            WRITE: begin
                // Overrun: the word is dropped, host sees bad checksum.
                if (rx_ready)
                    err_d = 1'b1;
                if (mem_ack) begin
                    we_d  = 1'b0;
                    idx_d = idx_q + 32'd1;
                    if (idx_q + 32'd1 == len_q) begin
                        state_d = SEND_RESP;
                        txw_d   = sum_q;
                    end else begin
                        state_d = GET_DATA;
                    end
                end
            end
            SEND_RESP: begin
                if (!tx_busy) begin
                    txs_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RST_PULSE: begin
                rcnt_d = rcnt_q + 32'd1;
                if (rcnt_q == 32'(RST_CYCLES - 1)) begin
                    mrst_d  = 1'b0;
                    state_d = SEND_RESP;
                    txw_d   = CMD_RST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            txw_q   <= '0;
            rcnt_q  <= '0;
            we_q    <= 1'b0;
            txs_q   <= 1'b0;
            hold_q  <= 1'b0;
            mrst_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            txw_q   <= txw_d;
            rcnt_q  <= rcnt_d;
            we_q    <= we_d;
            txs_q   <= txs_d;
            hold_q  <= hold_d;
            mrst_q  <= mrst_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_we   = we_q;
    assign tx_start = txs_q;
    assign tx_word  = txw_q;
    assign mcu_hold = hold_q;
    assign mcu_rst  = mrst_q;
    assign error    = err_q;

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Scoreboard bench for uart_prog_ctrl: expected writes and responses
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_uart_prog_ctrl;

    localparam logic [31:0] PROG = 32'h50524F47;
    localparam logic [31:0] RSTC = 32'h52535430;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ready;
    logic [31:0] rx_word;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_ack;
    logic        tx_start;
    logic [31:0] tx_word;
    logic        tx_busy;
    logic        mcu_hold;
    logic        mcu_rst;
    logic        error;

    wr_t         exp_wr[$];
    logic [31:0] exp_tx[$];

    int n_chk = 0;
    int n_err = 0;
    int ncyc = 0;
    int wcnt = 0;
    int ack_dly = 2;
    int ack_hold = 0;
    int tx_cnt = 0;
    int tx_ncyc = 0;
    int last_rx = 0;
    int rst_hi = 0;
    int s;

    uart_prog_ctrl #(
        .CLK_RATE   (1),
        .IW_TIMEOUT (1),
        .MAX_WORDS  (16384),
        .RST_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_ready (rx_ready),
        .rx_word  (rx_word),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .tx_start (tx_start),
        .tx_word  (tx_word),
        .tx_busy  (tx_busy),
        .mcu_hold (mcu_hold),
        .mcu_rst  (mcu_rst),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Monitor plus memory-ack model; mem_ack changes on negedge only.
    always @(negedge clk) begin
        wr_t e;
        ncyc++;
        if (mcu_rst) rst_hi++;
        if (tx_start) begin
            tx_cnt++;
            tx_ncyc = ncyc;
            chk("tx_busy_low", {31'b0, tx_busy}, 32'd0);
            chk("hold_drop", {31'b0, mcu_hold}, 32'd0);
            if (exp_tx.size() == 0)
                chk("tx_unexpected", 32'd1, 32'd0);
            else
                chk("tx_word", tx_word, exp_tx.pop_front());
        end
        if (mem_we && !rst) begin
            if (wcnt >= ack_dly && ack_hold == 0 && !mem_ack) begin
                mem_ack = 1'b1;
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_din, e.d);
                end
            end
            wcnt++;
        end else begin
            wcnt = 0;
            mem_ack = 1'b0;
        end
    end

    task automatic send(input logic [31:0] w);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        rx_word  = w;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        last_rx  = ncyc;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic wait_we_low();
        for (int i = 0; i < 50; i++) begin
            if (!mem_we) return;
            @(posedge clk);
            #1;
        end
        chk("we_low_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_tx(input int n);
        int st;
        st = tx_cnt;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tx_cnt != st) return;
        end
        chk("tx_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_word  = '0;
        tx_busy  = 1'b0;
        mem_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_txs", {31'b0, tx_start}, 32'd0);
        chk("rst_hold", {31'b0, mcu_hold}, 32'd0);
        chk("rst_mrst", {31'b0, mcu_rst}, 32'd0);
        chk("rst_err", {31'b0, error}, 32'd0);
        chk("rst_txw", tx_word, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // Basic three-word program with unaligned base address.
        push_wr(32'h100, 32'h11111111);
        push_wr(32'h104, 32'h22222222);
        push_wr(32'h108, 32'h33333333);
        exp_tx.push_back(32'h66666666);
        send(PROG);
        chk("hold_on", {31'b0, mcu_hold}, 32'd1);
        send(32'h00000102);
        send(32'd3);
        send(32'h11111111);
        wait_we_low();
        chk("hold_mid", {31'b0, mcu_hold}, 32'd1);
        send(32'h22222222);
        wait_we_low();
        send(32'h33333333);
        wait_we_low();
        wait_tx(20);
        chk("hold_off", {31'b0, mcu_hold}, 32'd0);
        chk("err_clean", {31'b0, error}, 32'd0);

        // Zero length and over-length payloads.
        exp_tx.push_back(32'h0);
        send(PROG);
        send(32'h10);
        send(32'd0);
        wait_tx(20);
        exp_tx.push_back(32'hFFFFFFFF);
        send(PROG);
        send(32'h10);
        send(32'd16385);
        wait_tx(20);

        // Unknown word and MCU reset command.
        exp_tx.push_back(32'hFFFFFFFF);
        send(32'hDEADBEEF);
        wait_tx(20);
        rst_hi = 0;
        exp_tx.push_back(RSTC);
        send(RSTC);
        wait_tx(40);
        chk("mrst_width", 32'(rst_hi), 32'd16);

        // Inter-word timeout after one of two words.
        push_wr(32'h200, 32'hAAAA0001);
        exp_tx.push_back(32'hFFFFFFFE);
        send(PROG);
        send(32'h200);
        send(32'd2);
        send(32'hAAAA0001);
        wait_we_low();
        wait_tx(1100);
        chk("tmo_delay",
            {31'b0, (tx_ncyc - last_rx >= 1000) && (tx_ncyc - last_rx <= 1012)},
            32'd1);
        chk("hold_tmo", {31'b0, mcu_hold}, 32'd0);

        // Overrun during a stalled write, then delayed response.
        ack_hold = 1;
        push_wr(32'h300, 32'h1);
        send(PROG);
        send(32'h300);
        send(32'd2);
        send(32'h1);
        repeat (3) @(posedge clk);
        send(32'h99999999);
        chk("ovr_err", {31'b0, error}, 32'd1);
        chk("ovr_we", {31'b0, mem_we}, 32'd1);
        chk("ovr_addr", mem_addr, 32'h300);
        chk("ovr_din", mem_din, 32'h1);
        ack_hold = 0;
        wait_we_low();
        tx_busy = 1'b1;
        push_wr(32'h304, 32'h2);
        exp_tx.push_back(32'h3);
        send(32'h2);
        wait_we_low();
        s = tx_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("tx_held", 32'(tx_cnt), 32'(s));
        tx_busy = 1'b0;
        wait_tx(10);
        chk("err_sticky", {31'b0, error}, 32'd1);

        // Reset in the middle of a pending write.
        ack_hold = 1;
        send(PROG);
        send(32'h400);
        send(32'd2);
        send(32'h5);
        chk("pre_rst_we", {31'b0, mem_we}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_hold", {31'b0, mcu_hold}, 32'd0);
        chk("mid_rst_txs", {31'b0, tx_start}, 32'd0);
        chk("mid_rst_err", {31'b0, error}, 32'd0);
        ack_hold = 0;
        push_wr(32'h400, 32'h7);
        exp_tx.push_back(32'h7);
        send(PROG);
        send(32'h400);
        send(32'd1);
        send(32'h7);
        wait_we_low();
        wait_tx(20);

        repeat (5) @(posedge clk);
        chk("wr_q_empty", 32'(exp_wr.size()), 32'd0);
        chk("tx_q_empty", 32'(exp_tx.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
